// File: rtl/shift_engine.sv
// ---------------------------------------------------------------------------
// shift_engine
//
// Purpose:
//   Frame-based parallel-in / parallel-out shift register. A frame begins
//   when start is seen while idle; the parallel word is loaded and then
//   exactly WIDTH shift strobes (peripheralClkEdge) are accepted. On each
//   accepted strobe one bit enters from serialDataIn while serialDataOut
//   presents the outgoing bit. A one-cycle done pulse follows the final
//   shift. Strobes while idle and start requests during a frame are ignored.
//
// Optional feature (macro SHIFT_ENGINE_LSB_FIRST_EN):
//   Adds the lsbFirst input. It is sampled at frame start and held for the
//   whole frame. With the macro undefined the engine is MSB-first only.
//
// Parameters:
//   WIDTH  shift register width in bits (legal 2..32)
//
// Ports:
//   clk                in   system clock, all state on rising edge
//   reset              in   synchronous active-high reset
//   peripheralClkEdge  in   one-cycle shift strobe
//   start              in   frame start request (honoured only when idle)
//   parallelDataIn     in   word loaded at frame start
//   serialDataIn       in   bit shifted in on each accepted strobe
//   lsbFirst           in   (macro only) shift direction for the next frame
//   parallelDataOut    out  current register contents
//   serialDataOut      out  outgoing bit (MSB, or LSB in LSB-first frames)
//   busy               out  high while a frame is in progress
//   done               out  one-cycle pulse after the final shift
//
// State table:
//   state | meaning
//   IDLE  | no frame; waiting for start, strobes ignored
//   SHIFT | frame in progress; each strobe shifts one bit
// ---------------------------------------------------------------------------
module shift_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             peripheralClkEdge,
    input  logic             start,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
`ifdef SHIFT_ENGINE_LSB_FIRST_EN
    input  logic             lsbFirst,
`endif
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             serialDataOut,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

`ifdef SHIFT_ENGINE_LSB_FIRST_EN
    // Direction latched at frame start so mid-frame changes on lsbFirst
    // cannot corrupt a frame in flight.
    logic               lsb_q, lsb_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef SHIFT_ENGINE_LSB_FIRST_EN
            lsb_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef SHIFT_ENGINE_LSB_FIRST_EN
            lsb_q   <= lsb_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef SHIFT_ENGINE_LSB_FIRST_EN
        lsb_d   = lsb_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = parallelDataIn;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SHIFT_ENGINE_LSB_FIRST_EN
                    lsb_d   = lsbFirst;
`endif
                end
            end

            SHIFT: begin
                if (peripheralClkEdge) begin
`ifdef SHIFT_ENGINE_LSB_FIRST_EN
                    if (lsb_q) begin
                        shift_d = {serialDataIn, shift_q[WIDTH-1:1]};
                    end else begin
                        shift_d = {shift_q[WIDTH-2:0], serialDataIn};
                    end
`else
                    shift_d = {shift_q[WIDTH-2:0], serialDataIn};
`endif
                    // Counter stops at WIDTH-1: the last strobe closes the
                    // frame instead of incrementing.
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign parallelDataOut = shift_q;
    assign busy            = (state_q == SHIFT);
    assign done            = done_q;

`ifdef SHIFT_ENGINE_LSB_FIRST_EN
    assign serialDataOut = lsb_q ? shift_q[0] : shift_q[WIDTH-1];
`else
    assign serialDataOut = shift_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_shift_engine.sv
module tb_shift_engine;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             peripheralClkEdge;
    logic             start;
    logic [WIDTH-1:0] parallelDataIn;
    logic             serialDataIn;
`ifdef SHIFT_ENGINE_LSB_FIRST_EN
    logic             lsbFirst;
`endif
    logic [WIDTH-1:0] parallelDataOut;
    logic             serialDataOut;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    shift_engine #(.WIDTH(WIDTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .peripheralClkEdge (peripheralClkEdge),
        .start             (start),
        .parallelDataIn    (parallelDataIn),
        .serialDataIn      (serialDataIn),
`ifdef SHIFT_ENGINE_LSB_FIRST_EN
        .lsbFirst          (lsbFirst),
`endif
        .parallelDataOut   (parallelDataOut),
        .serialDataOut     (serialDataOut),
        .busy              (busy),
        .done              (done)
    );

    // Advance one clock; outputs are settled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (done) done_seen++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        peripheralClkEdge = 1'b0;
        parallelDataIn = 8'h00;
        serialDataIn = 1'b0;
        step();
        step();
        n_cmp++; if (parallelDataOut !== 8'h00) begin n_err++; $display("FAIL reset_pdo got %h exp 00", parallelDataOut); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
        n_cmp++; if (serialDataOut !== 1'b0) begin n_err++; $display("FAIL reset_sdo got %b exp 0", serialDataOut); end
        // Reset wins over start and strobe in the same cycle.
        start = 1'b1;
        parallelDataIn = 8'hFF;
        peripheralClkEdge = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_prio_busy got %b exp 0", busy); end
        n_cmp++; if (parallelDataOut !== 8'h00) begin n_err++; $display("FAIL reset_prio_pdo got %h exp 00", parallelDataOut); end
        start = 1'b0;
        peripheralClkEdge = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_msb_frame();
        logic [7:0] sdo_exp;
        logic [7:0] sdi_bits;
        sdo_exp = 8'hA5;
        sdi_bits = 8'h3C;
        done_seen = 0;
        parallelDataIn = 8'hA5;
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL msb_busy_start got %b exp 1", busy); end
        n_cmp++; if (parallelDataOut !== 8'hA5) begin n_err++; $display("FAIL msb_load got %h exp a5", parallelDataOut); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (serialDataOut !== sdo_exp[7-i]) begin
                n_err++; $display("FAIL msb_sdo bit %0d got %b exp %b", i, serialDataOut, sdo_exp[7-i]);
            end
            serialDataIn = sdi_bits[7-i];
            peripheralClkEdge = 1'b1;
            step();
            peripheralClkEdge = 1'b0;
            if (i < 7) begin
                step();
                step();
            end
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL msb_done got %b exp 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL msb_busy_done got %b exp 0", busy); end
        n_cmp++; if (parallelDataOut !== 8'h3C) begin n_err++; $display("FAIL msb_final got %h exp 3c", parallelDataOut); end
        step();
        step();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL msb_done_clear got %b exp 0", done); end
        n_cmp++; if (done_seen !== 1) begin n_err++; $display("FAIL msb_done_count got %0d exp 1", done_seen); end
    endtask

    task automatic test_ignored();
        logic [7:0] exp_reg;
        logic [7:0] sdi_bits;
        sdi_bits = 8'hC3;
        done_seen = 0;
        // Strobes while idle must not shift.
        serialDataIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            peripheralClkEdge = 1'b1;
            step();
            peripheralClkEdge = 1'b0;
            step();
        end
        n_cmp++; if (parallelDataOut !== 8'h3C) begin n_err++; $display("FAIL idle_strobe_pdo got %h exp 3c", parallelDataOut); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_strobe_busy got %b exp 0", busy); end

        parallelDataIn = 8'h5A;
        start = 1'b1;
        step();
        start = 1'b0;
        exp_reg = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            serialDataIn = sdi_bits[7-i];
            peripheralClkEdge = 1'b1;
            step();
            peripheralClkEdge = 1'b0;
            exp_reg = {exp_reg[6:0], sdi_bits[7-i]};
            if (i == 2 || i == 5) begin
                // Mid-frame start must not reload.
                parallelDataIn = 8'hFF;
                start = 1'b1;
                step();
                start = 1'b0;
                n_cmp++;
                if (parallelDataOut !== exp_reg) begin
                    n_err++; $display("FAIL mid_start_pdo after %0d got %h exp %h", i + 1, parallelDataOut, exp_reg);
                end
            end
            if (i == 6) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_busy_7 got %b exp 1", busy); end
            end
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ign_done got %b exp 1", done); end
        n_cmp++; if (parallelDataOut !== 8'hC3) begin n_err++; $display("FAIL ign_final got %h exp c3", parallelDataOut); end
        step();
        n_cmp++; if (done_seen !== 1) begin n_err++; $display("FAIL ign_done_count got %0d exp 1", done_seen); end
    endtask

    task automatic test_back_to_back();
        parallelDataIn = 8'h81;
        start = 1'b1;
        step();
        start = 1'b0;
        serialDataIn = 1'b0;
        peripheralClkEdge = 1'b1;
        for (int i = 0; i < 8; i++) step();
        peripheralClkEdge = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done got %b exp 1", done); end
        n_cmp++; if (parallelDataOut !== 8'h00) begin n_err++; $display("FAIL b2b_first_pdo got %h exp 00", parallelDataOut); end
        parallelDataIn = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b exp 1", busy); end
        n_cmp++; if (parallelDataOut !== 8'hFF) begin n_err++; $display("FAIL b2b_load got %h exp ff", parallelDataOut); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_clear got %b exp 0", done); end
        serialDataIn = 1'b0;
        peripheralClkEdge = 1'b1;
        for (int i = 0; i < 8; i++) step();
        peripheralClkEdge = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_second_done got %b exp 1", done); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [7:0] sdi_bits;
        sdi_bits = 8'h96;
        parallelDataIn = 8'hA5;
        start = 1'b1;
        step();
        start = 1'b0;
        serialDataIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            peripheralClkEdge = 1'b1;
            step();
            peripheralClkEdge = 1'b0;
            step();
        end
        n_cmp++; if (parallelDataOut !== 8'h5F) begin n_err++; $display("FAIL mid_pre_reset got %h exp 5f", parallelDataOut); end
        done_seen = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy got %b exp 0", busy); end
        n_cmp++; if (parallelDataOut !== 8'h00) begin n_err++; $display("FAIL mid_reset_pdo got %h exp 00", parallelDataOut); end
        // Strobes after the abort must not produce a done.
        peripheralClkEdge = 1'b1;
        for (int i = 0; i < 6; i++) step();
        peripheralClkEdge = 1'b0;
        n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL mid_reset_no_done got %0d exp 0", done_seen); end

        parallelDataIn = 8'h0F;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            serialDataIn = sdi_bits[7-i];
            peripheralClkEdge = 1'b1;
            step();
            peripheralClkEdge = 1'b0;
            if (i < 7) step();
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL post_reset_done got %b exp 1", done); end
        n_cmp++; if (parallelDataOut !== 8'h96) begin n_err++; $display("FAIL post_reset_pdo got %h exp 96", parallelDataOut); end
        step();
    endtask

`ifdef SHIFT_ENGINE_LSB_FIRST_EN
    task automatic test_lsb_first();
        logic exp_sdo;
        lsbFirst = 1'b1;
        parallelDataIn = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        lsbFirst = 1'b0;
        serialDataIn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_sdo = (i == 0);
            n_cmp++;
            if (serialDataOut !== exp_sdo) begin
                n_err++; $display("FAIL lsb_sdo bit %0d got %b exp %b", i, serialDataOut, exp_sdo);
            end
            peripheralClkEdge = 1'b1;
            step();
            peripheralClkEdge = 1'b0;
            if (i < 7) step();
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL lsb_done got %b exp 1", done); end
        n_cmp++; if (parallelDataOut !== 8'hFF) begin n_err++; $display("FAIL lsb_final got %h exp ff", parallelDataOut); end
        step();
    endtask
`endif

    initial begin
`ifdef SHIFT_ENGINE_LSB_FIRST_EN
        lsbFirst = 1'b0;
`endif
        test_reset();
        test_msb_frame();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
`ifdef SHIFT_ENGINE_LSB_FIRST_EN
        test_lsb_first();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
